// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access sequencer.
// Provides access-type codes, FSM state encoding and the alignment rule.
// Combinational helpers only; no latency, no backpressure.
package mem_pkg;

  // Access-type codes carried in EX/M bhw_type. Unlisted codes act as word.
  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b010;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Natural alignment: bytes never fault, halfwords need an even address,
  // words (and every undefined code) need a word-aligned address.
  function automatic logic is_aligned(input logic [2:0] bhw_type,
                                      input logic [1:0] addr_lo);
    case (bhw_type)
      BHW_B, BHW_BU: is_aligned = 1'b1;
      BHW_H, BHW_HU: is_aligned = ~addr_lo[0];
      default:       is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated store data, and load
// lane extraction with sign or zero extension. Purely combinational.
// Ports: i_st_* = store-side type/offset/data -> o_be, o_wdata;
//        i_ld_* = load-side type/offset/memory word -> o_ld_data.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_st_type,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    case (i_st_type)
      BHW_B, BHW_BU: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      BHW_H, BHW_HU: begin
        o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    ld_byte = i_ld_word[7:0];
      2'd1:    ld_byte = i_ld_word[15:8];
      2'd2:    ld_byte = i_ld_word[23:16];
      default: ld_byte = i_ld_word[31:24];
    endcase
    ld_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

    case (i_ld_type)
      BHW_B:   o_ld_data = {{24{ld_byte[7]}}, ld_byte};
      BHW_BU:  o_ld_data = {24'd0, ld_byte};
      BHW_H:   o_ld_data = {{16{ld_half[15]}}, ld_half};
      BHW_HU:  o_ld_data = {16'd0, ld_half};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: turns the EX/M load/store into one aligned word
// transaction (req held until ack), stalls the pipeline meanwhile, returns
// extended load data in DONE, flags misaligned accesses and timeouts.
// Ports: i_ex_m_* from EX/M; i_dmem_*/o_dmem_* memory handshake;
//        o_stall, o_rdata(_valid), o_misalign, o_timeout to the pipeline.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ex_m_mem_read,
  input  logic        i_ex_m_mem_write,
  input  logic [2:0]  i_ex_m_bhw_type,
  input  logic [31:0] i_ex_m_alu_result,
  input  logic [31:0] i_ex_m_write_data,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_misalign,
  output logic        o_timeout
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;

  logic        acc;
  logic        aligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] ld_ext;

  // Store side is fed from the live EX/M fields (latched on entry to
  // ACCESS); load side uses the latched type/offset so the lane stays
  // stable while the pipeline is frozen.
  mem_lane_align u_lane (
    .i_st_type (i_ex_m_bhw_type),
    .i_st_off  (i_ex_m_alu_result[1:0]),
    .i_st_data (i_ex_m_write_data),
    .o_be      (lane_be),
    .o_wdata   (lane_wdata),
    .i_ld_type (type_q),
    .i_ld_off  (off_q),
    .i_ld_word (i_dmem_rdata),
    .o_ld_data (ld_ext)
  );

  always_comb begin
    acc     = i_ex_m_mem_read | i_ex_m_mem_write;
    aligned = is_aligned(i_ex_m_bhw_type, i_ex_m_alu_result[1:0]);

    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    off_d   = off_q;
    we_d    = we_q;
    rdata_d = rdata_q;

    o_stall       = 1'b0;
    o_misalign    = 1'b0;
    o_timeout     = 1'b0;
    o_rdata_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (acc) begin
          if (aligned) begin
            o_stall = 1'b1;
            addr_d  = {i_ex_m_alu_result[31:2], 2'b00};
            be_d    = lane_be;
            wdata_d = lane_wdata;
            type_d  = i_ex_m_bhw_type;
            off_d   = i_ex_m_alu_result[1:0];
            we_d    = i_ex_m_mem_write;  // write wins when both are set
            state_d = ST_ACCESS;
          end else begin
            o_misalign = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        o_stall = 1'b1;
        if (i_dmem_ack) begin
          rdata_d = we_q ? '0 : ld_ext;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          o_timeout = 1'b1;
          rdata_d   = '0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        // EX/M advances at the end of this cycle, so IDLE sees the next
        // instruction and the finished one cannot re-trigger.
        o_rdata_valid = ~we_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      type_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      off_q   <= off_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_dmem_req   = (state_q == ST_ACCESS);
  assign o_dmem_we    = o_dmem_req & we_q;
  assign o_dmem_be    = o_dmem_req ? be_q : 4'b0000;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_rdata      = rdata_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage sequencer between the EX/M pipeline register outputs and a variable-latency data memory with a req/ack handshake.
- Converts each load/store held in EX/M into one aligned word transaction with byte enables, and stalls the pipeline until that transaction completes.
- Extracts and sign/zero-extends load data, and flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without ack before the access is aborted (1..255).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_ex_m_mem_read  in  1  load held in EX/M
- i_ex_m_mem_write  in  1  store held in EX/M
- i_ex_m_bhw_type  in  3  access type (encoding in package)
- i_ex_m_alu_result  in  32  byte address
- i_ex_m_write_data  in  32  store data, right-aligned
- i_dmem_ack  in  1  memory completion, 1 cycle
- i_dmem_rdata  in  32  read word, valid with ack
- o_dmem_req  out  1  request, held until ack
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  32  word address, bits [1:0] = 0
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  32  lane-replicated store data
- o_stall  out  1  freeze IF/ID/EX and the EX/M register
- o_rdata  out  32  extended load result
- o_rdata_valid  out  1  o_rdata valid (DONE cycle)
- o_misalign  out  1  misaligned access, 1-cycle pulse
- o_timeout  out  1  access aborted, 1-cycle pulse

Behaviour:
- Clock is i_clk; reset is i_reset, synchronous and active-high.
- Reset forces state IDLE, timeout counter 0, and all latched registers 0.
  - o_dmem_req, o_dmem_we, o_dmem_be, o_stall, o_rdata_valid, o_misalign and o_timeout all read 0.
  - o_dmem_addr, o_dmem_wdata and o_rdata read 0.
  - Reset during ACCESS drops o_dmem_req at that edge; any late ack is ignored.
- Access condition: acc = mem_read | mem_write. If both are set, the access is a write.
- Alignment rules:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - Byte accesses are always aligned.
- IDLE:
  - acc and aligned: o_stall = 1 combinationally. Latch the word address, be, lane data, type, addr[1:0] and we. Next state ACCESS.
  - acc and misaligned: o_misalign = 1 combinationally. No request, no stall, stay IDLE.
- ACCESS:
  - o_stall = 1 and o_dmem_req = 1, decoded from state; request fields stay stable.
  - i_dmem_ack: capture the extended read data (writes capture 0), go to DONE.
  - No ack: counter++. When counter = TIMEOUT_CYCLES-1 with no ack, o_timeout = 1 in that cycle, go to DONE with o_rdata = 0.
- DONE:
  - o_stall = 0 and o_rdata_valid = 1 (loads only); EX/M advances at the end of this cycle.
  - Always returns to IDLE and never re-triggers on the same instruction.
- Latency: with ack in the first ACCESS cycle, an access takes 3 cycles (IDLE, ACCESS, DONE) with 2 stall cycles. Each extra wait cycle adds 1.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << (2·addr[1])
  - word: 1111
- Write data:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Read extraction:
  - Select the byte or halfword lane using the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Ack is ignored outside ACCESS.
- Undefined bhw_type codes behave as word.

Decomposition:
- Package mem_pkg:
  - bhw_type constants: BHW_B = 000, BHW_H = 001, BHW_W = 010, BHW_BU = 100, BHW_HU = 101.
  - FSM state encoding: IDLE / ACCESS / DONE.
- Sub-module mem_lane_align (combinational): be and wdata generation plus read extraction/extension. Shared with a future store-forwarding path.
- The FSM and counter live in mem_access_ctrl.

Test Plan:
- SW addr 0x0000_0010, wd 0xDEADBEEF, ack in first ACCESS cycle:
  - req = 1, we = 1, addr 0x10, be 1111, wdata 0xDEADBEEF.
  - o_stall high 2 cycles; return to IDLE.
- LB addr 0x13, rdata 0x80FF_0102 with 3 wait cycles:
  - be 1000, o_stall high 5 cycles.
  - DONE: o_rdata 0xFFFF_FF80, o_rdata_valid = 1.
- LHU addr 0x22, rdata 0x8001_1234:
  - be 1100, o_rdata 0x0000_8001.
  - The same access as LH gives 0xFFFF_8001.
- LW addr 0x21 and SH addr 0x03:
  - o_misalign pulses 1 cycle each.
  - o_dmem_req stays 0 and o_stall stays 0.
- TIMEOUT_CYCLES = 4, load with no ack:
  - o_timeout pulses in the 4th ACCESS cycle, o_rdata = 0.
  - Stall drops in DONE; an ack arriving later is ignored.
- Back-to-back load, store with i_reset asserted in the 2nd ACCESS cycle of the load:
  - Next cycle: IDLE, req = 0, stall = 0, all outputs 0.
  - Store then proceeds normally after reset release.
